// File: rtl/lcd_text_buffer.sv
// 2x16 LCD character frame fed by a byte stream of printable characters and control codes.
// Latency: single-edge effect for print/newline/backspace; SCROLL takes 16 cycles, CLEAR 32.
// Backpressure: in_ready drops for the whole CLEAR/SCROLL sequence and while Reset is low.
module lcd_text_buffer #(
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic         CLOCK_50,
    input  logic         Reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] characters,
    output logic [4:0]   cursor,
    output logic         busy,
    output logic         frame_done
);

    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

    state_t     state, state_nxt;
    logic [4:0] step, step_nxt;
    logic [7:0] buf_q [32];

    logic       accept;
    logic       is_print;
    logic       wa_en, wb_en;
    logic [4:0] wa_idx, wb_idx;
    logic [7:0] wa_dat, wb_dat;
    logic [4:0] cur_nxt;
    logic       fd_nxt;

    assign in_ready = (state == IDLE) && Reset;
    assign accept   = in_valid && in_ready;
    assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);

    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_print && cursor == 5'd31)
                        state_nxt = SCROLL;
                    else if (in_data == 8'h0A && cursor[4])
                        state_nxt = SCROLL;
                    else if (in_data == 8'h0C)
                        state_nxt = CLEAR;
                end
            end
            SCROLL: begin
                if (step == 5'd15) state_nxt = IDLE;
                else               step_nxt  = step + 5'd1;
            end
            CLEAR: begin
                if (step == 5'd31) state_nxt = IDLE;
                else               step_nxt  = step + 5'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Two write ports: scroll moves line 1 up and blanks it in the same cycle.
    always_comb begin
        wa_en   = 1'b0;
        wa_idx  = '0;
        wa_dat  = BLANK;
        wb_en   = 1'b0;
        wb_idx  = '0;
        wb_dat  = BLANK;
        cur_nxt = cursor;
        fd_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        wa_en  = 1'b1;
                        wa_idx = cursor;
                        wa_dat = in_data;
                        if (cursor != 5'd31) begin
                            cur_nxt = cursor + 5'd1;
                            fd_nxt  = 1'b1;
                        end
                    end else if (in_data == 8'h0A) begin
                        if (!cursor[4]) begin
                            cur_nxt = 5'd16;
                            fd_nxt  = 1'b1;
                        end
                    end else if (in_data == 8'h08) begin
                        fd_nxt = 1'b1;
                        if (cursor != 5'd0) begin
                            cur_nxt = cursor - 5'd1;
                            wa_en   = 1'b1;
                            wa_idx  = cursor - 5'd1;
                        end
                    end
                end
            end
            SCROLL: begin
                wa_en  = 1'b1;
                wa_idx = {1'b0, step[3:0]};
                wa_dat = buf_q[{1'b1, step[3:0]}];
                wb_en  = 1'b1;
                wb_idx = {1'b1, step[3:0]};
                if (step == 5'd15) begin
                    cur_nxt = 5'd16;
                    fd_nxt  = 1'b1;
                end
            end
            CLEAR: begin
                wa_en  = 1'b1;
                wa_idx = step;
                if (step == 5'd31) begin
                    cur_nxt = 5'd0;
                    fd_nxt  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) buf_q[i] <= BLANK;
            cursor     <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (wa_en) buf_q[wa_idx] <= wa_dat;
            if (wb_en) buf_q[wb_idx] <= wb_dat;
            cursor     <= cur_nxt;
            busy       <= (state_nxt != IDLE);
            frame_done <= fd_nxt;
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_pack
        assign characters[8*g+7:8*g] = buf_q[g];
    end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Randomized and directed stimulus against an operation-level model of the LCD text buffer.
module tb_lcd_text_buffer;

    logic         CLOCK_50;
    logic         Reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] characters;
    logic [4:0]   cursor;
    logic         busy;
    logic         frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each command's final effect is applied on the accept edge; m_wait
    // counts down the cycles the block stays busy afterwards.
    logic [7:0] m_mem [32];
    int         m_cur;
    int         m_wait;
    logic       m_fd;

    lcd_text_buffer #(.BLANK(8'h20)) dut (
        .CLOCK_50  (CLOCK_50),
        .Reset     (Reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .characters(characters),
        .cursor    (cursor),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] packed_model();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[8*i +: 8] = m_mem[i];
        return v;
    endfunction

    task automatic m_scroll();
        for (int i = 0; i < 16; i++) begin
            m_mem[i]      = m_mem[i + 16];
            m_mem[i + 16] = 8'h20;
        end
        m_cur  = 16;
        m_wait = 16;
    endtask

    task automatic model_edge(input logic rst, input logic vld, input logic [7:0] d);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
            m_cur  = 0;
            m_wait = 0;
            m_fd   = 1'b0;
        end else if (m_wait > 0) begin
            m_wait--;
            m_fd = (m_wait == 0);
        end else begin
            m_fd = 1'b0;
            if (vld) begin
                if (d >= 8'h20 && d <= 8'h7E) begin
                    m_mem[m_cur] = d;
                    if (m_cur == 31) m_scroll();
                    else begin
                        m_cur++;
                        m_fd = 1'b1;
                    end
                end else if (d == 8'h0A) begin
                    if (m_cur < 16) begin
                        m_cur = 16;
                        m_fd  = 1'b1;
                    end else m_scroll();
                end else if (d == 8'h08) begin
                    m_fd = 1'b1;
                    if (m_cur > 0) begin
                        m_cur--;
                        m_mem[m_cur] = 8'h20;
                    end
                end else if (d == 8'h0C) begin
                    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
                    m_cur  = 0;
                    m_wait = 32;
                end
            end
        end
    endtask

    // Called at a falling edge: drive, clock once, then compare at the next falling edge.
    task automatic step(input logic rst, input logic vld, input logic [7:0] d);
        Reset    = rst;
        in_valid = vld;
        in_data  = d;
        #1;
        chk("in_ready", in_ready, rst && (m_wait == 0));
        @(posedge CLOCK_50);
        model_edge(rst, vld, d);
        @(negedge CLOCK_50);
        chk("busy", busy, m_wait != 0);
        chk("frame_done", frame_done, m_fd);
        if (m_wait == 0) begin
            chk("cursor", cursor, m_cur[4:0]);
            chk("characters", characters, packed_model());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, 1'b1, d);
    endtask

    initial begin
        logic       rst, vld;
        logic [7:0] d;
        int         r;

        Reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        m_cur    = 0;
        m_wait   = 0;
        m_fd     = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        @(negedge CLOCK_50);

        step(1'b0, 1'b1, 8'h41);
        step(1'b0, 1'b0, 8'h00);
        chk("rst_cursor", cursor, 5'd0);
        chk("rst_busy", busy, 1'b0);
        idle(1);

        // "HI"
        send(8'h48);
        send(8'h49);
        chk("hi_b0", characters[7:0], 8'h48);
        chk("hi_b1", characters[15:8], 8'h49);
        chk("hi_cursor", cursor, 5'd2);
        chk("hi_rest", characters[255:16], {30{8'h20}});

        // Fill the whole frame, forcing a scroll on the 32nd character.
        send(8'h0C);
        idle(32);
        for (int i = 0; i < 32; i++) send(8'h41 + 8'(i));
        idle(16);
        chk("fill_b0", characters[7:0], 8'h51);
        chk("fill_b15", characters[127:120], 8'h60);
        chk("fill_line1", characters[255:128], {16{8'h20}});
        chk("fill_cursor", cursor, 5'd16);

        // Newline from line 0, then from line 1.
        send(8'h0C);
        idle(32);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        send(8'h0A);
        chk("nl_cursor", cursor, 5'd16);
        chk("nl_busy", busy, 1'b0);
        send(8'h0A);
        idle(16);
        chk("nl2_cursor", cursor, 5'd16);

        // Backspace at the origin and after one character.
        send(8'h0C);
        idle(32);
        send(8'h08);
        chk("bs0_cursor", cursor, 5'd0);
        send(8'h5A);
        send(8'h08);
        chk("bs_b0", characters[7:0], 8'h20);
        chk("bs_cursor", cursor, 5'd0);

        // Clear with a held 'Q' behind it.
        send(8'h0C);
        for (int i = 0; i < 33; i++) send(8'h51);
        chk("clrq_b0", characters[7:0], 8'h51);
        chk("clrq_cursor", cursor, 5'd1);

        // Reset in the middle of a clear.
        send(8'h0C);
        idle(10);
        step(1'b0, 1'b0, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_chars", characters, {32{8'h20}});
        idle(2);

        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            vld = ($urandom_range(0, 2) != 0);
            r   = $urandom_range(0, 15);
            if (r <= 9)       d = 8'($urandom_range(8'h20, 8'h7E));
            else if (r == 10) d = 8'h0A;
            else if (r == 11) d = 8'h08;
            else if (r == 12) d = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h2E;
            else if (r == 13) d = 8'h7F;
            else if (r == 14) d = 8'($urandom_range(8'h80, 8'hFF));
            else              d = 8'($urandom_range(8'h00, 8'h1F));
            step(rst, vld, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_text_buffer.md
LCD_TEXT_BUFFER -- requirements
Module: lcd_text_buffer

Interface
REQ-001 SHALL have parameter BLANK, default 8'h20, fill character used by reset, clear, scroll and backspace.
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset; one clock, synchronous, active-low.
REQ-004 SHALL have port in_data  input  8  character or control code from the game logic.
REQ-005 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block can accept in_data this cycle.
REQ-007 SHALL have port characters  output  256  2x16 frame for the LCD driver. Byte i is characters[8i+7:8i]. Line 0 is i=0..15, line 1 is i=16..31.
REQ-008 SHALL have port cursor  output  5  index of the next write position, 0..31.
REQ-009 SHALL have port busy  output  1  high during CLEAR or SCROLL.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when a command's effect on characters is complete.

Function
REQ-011 SHALL accept a code only on a rising edge where in_valid=1 and in_ready=1; in_data is otherwise ignored.
REQ-012 SHALL drive in_ready = (state==IDLE) combinationally, and drive it 0 while Reset=0.
REQ-013 SHALL implement states IDLE, CLEAR and SCROLL, each with a 5-bit step counter.
REQ-014 Printable code 8'h20..8'h7E: SHALL write to byte[cursor] on the accepting edge, visible the next cycle.
  - cursor<31: cursor+1, frame_done pulses the next cycle.
  - cursor=31: SHALL enter SCROLL.
REQ-015 8'h0A newline:
  - cursor 0..15: cursor <= 16, frame_done pulses, no buffer change.
  - cursor 16..31: SHALL enter SCROLL.
REQ-016 8'h08 backspace:
  - cursor=0: no change, frame_done still pulses.
  - otherwise: cursor-1 and byte[cursor-1] <= BLANK in the same edge.
REQ-017 8'h0C clear: SHALL enter CLEAR with counter=0.
REQ-018 Any other code (incl. 8'h7F and >=8'h80): SHALL be accepted and discarded. No state change, no frame_done.
REQ-019 SCROLL lasts exactly 16 cycles (counter k=0..15).
  - Each cycle: byte[k] <= byte[16+k], byte[16+k] <= BLANK.
  - After k=15: cursor <= 16, state <= IDLE, frame_done pulses one cycle later.
REQ-020 CLEAR lasts exactly 32 cycles (counter k=0..31).
  - Each cycle: byte[k] <= BLANK.
  - After k=31: cursor <= 0, state <= IDLE, frame_done pulses one cycle later.
REQ-021 busy SHALL equal (state!=IDLE). in_ready SHALL be 0 for the whole CLEAR/SCROLL duration and return to 1 the cycle after the final step.
REQ-022 The character written at position 31 SHALL be the byte moved to position 15 by the following SCROLL.
REQ-023 Cursor arithmetic is 5-bit. The cursor SHALL never wrap 31->0; the only paths to 0 are reset and CLEAR.
REQ-024 All outputs except in_ready SHALL be registered.

Reset
REQ-025 Reset=0 at a rising edge SHALL set:
  - all 32 bytes to BLANK,
  - cursor=0, state=IDLE, counter=0,
  - busy=0, frame_done=0.
REQ-026 Reset SHALL take priority over any in-progress CLEAR/SCROLL and over a simultaneous in_valid. The interrupted operation is abandoned, not resumed.
REQ-027 After Reset returns to 1, in_ready SHALL be 1 in the first cycle.

Verification
REQ-028 Reset, then send "HI" (8'h48, 8'h49) -> byte0=8'h48, byte1=8'h49, cursor=2, two frame_done pulses, bytes 2..31 = 8'h20.
REQ-029 Fill 32 chars 'A'..'`' (8'h41..8'h60) -> busy=1 and in_ready=0 for exactly 16 cycles after the 32nd accept; then bytes 0..15 = 8'h51..8'h60, bytes 16..31 = 8'h20, cursor=16.
REQ-030 Cursor=5, send 8'h0A -> cursor=16, no busy. Send 8'h0A again -> 16-cycle SCROLL, cursor=16.
REQ-031 Cursor=0, send 8'h08 -> no change. Send 'Z' then 8'h08 -> byte0=8'h20, cursor=0.
REQ-032 Send 8'h0C with in_valid held high carrying 'Q' -> in_ready=0 for 32 cycles, all bytes 8'h20, cursor=0; 'Q' accepted on the first cycle in_ready=1, giving byte0=8'h51.
REQ-033 Assert Reset=0 for one cycle at CLEAR step 10 -> next cycle all bytes 8'h20, cursor=0, busy=0, in_ready=1 once Reset=1.
